// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and defaults for the register-file write-back arbiter.
//   req_idx_e     : requester index (alu=0, mem=1, dbg=2), also the grant bit order
//   NREQ          : number of write requesters
//   DEF_WIDTH     : default register data width
//   DEF_ADDR_SIZE : default register address width
package rf_wb_pkg;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MEM = 2'd1,
        REQ_DBG = 2'd2
    } req_idx_e;

    localparam int NREQ          = 3;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_SIZE = 4;

endpackage

// File: rtl/rf_wb_arb_if.sv
// rf_wb_arb_if: bus bundle between the write requesters, the register file and
// the arbiter.
//   req_X/wa_X/din_X/gnt_X (X = alu, mem, dbg) : write request handshake
//   link_req                                   : branch-and-link request
//   rf_wen/rf_wa/rf_din/rf_link                : register file write port
//   mark_req/mark_addr/mark_rdy                : load-issue scoreboard mark port
//   qa/qb/hazard                               : operand hazard query
// Modports: slave = arbiter side, master = requester / register-file side.
interface rf_wb_arb_if
    import rf_wb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
    logic                 req_alu, req_mem, req_dbg;
    logic [ADDR_SIZE-1:0] wa_alu, wa_mem, wa_dbg;
    logic [WIDTH-1:0]     din_alu, din_mem, din_dbg;
    logic                 gnt_alu, gnt_mem, gnt_dbg;
    logic                 link_req;
    logic                 rf_wen;
    logic [ADDR_SIZE-1:0] rf_wa;
    logic [WIDTH-1:0]     rf_din;
    logic                 rf_link;
    logic                 mark_req;
    logic [ADDR_SIZE-1:0] mark_addr;
    logic                 mark_rdy;
    logic [ADDR_SIZE-1:0] qa, qb;
    logic                 hazard;

    modport slave (
        input  req_alu, req_mem, req_dbg, wa_alu, wa_mem, wa_dbg,
               din_alu, din_mem, din_dbg, link_req, mark_req, mark_addr, qa, qb,
        output gnt_alu, gnt_mem, gnt_dbg, rf_wen, rf_wa, rf_din, rf_link,
               mark_rdy, hazard
    );

    modport master (
        output req_alu, req_mem, req_dbg, wa_alu, wa_mem, wa_dbg,
               din_alu, din_mem, din_dbg, link_req, mark_req, mark_addr, qa, qb,
        input  gnt_alu, gnt_mem, gnt_dbg, rf_wen, rf_wa, rf_din, rf_link,
               mark_rdy, hazard
    );
endinterface

// File: rtl/rr_arb3.sv
// rr_arb3: three-way round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req[2:0]   : requests (bit index = req_idx_e)
//   advance    : a transfer happened this cycle; move priority past the winner
//   gnt[2:0]   : combinational one-hot grant, all zero while reset is high
module rr_arb3
    import rf_wb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    // ptr names the requester with highest priority this cycle.
    req_idx_e ptr;

    logic [NREQ-1:0] rot, rg;

    // Rotate so the priority holder sits at bit 0, take the lowest set bit,
    // then rotate the one-hot result back.
    always_comb begin
        rot = req;
        case (ptr)
            REQ_MEM: rot = {req[0], req[2], req[1]};
            REQ_DBG: rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
        rg[0] = rot[0];
        rg[1] = rot[1] & ~rot[0];
        rg[2] = rot[2] & ~rot[1] & ~rot[0];
        gnt = '0;
        if (!reset) begin
            case (ptr)
                REQ_MEM: gnt = {rg[1], rg[0], rg[2]};
                REQ_DBG: gnt = {rg[0], rg[2], rg[1]};
                default: gnt = rg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= REQ_ALU;
        end else if (advance) begin
            if (gnt[REQ_ALU])      ptr <= REQ_MEM;
            else if (gnt[REQ_MEM]) ptr <= REQ_DBG;
            else if (gnt[REQ_DBG]) ptr <= REQ_ALU;
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: register-file write-back arbiter with optional load scoreboard.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : rf_wb_arb_if.slave (requests/grants, register file write
//                port, scoreboard mark port, hazard query)
// Grants are combinational and round-robin (alu, mem, dbg); link_req blocks
// all grants and is echoed as rf_link one cycle later. Accepted writes appear
// on rf_wen/rf_wa/rf_din one cycle after the transfer.
// Build option: define RF_WB_ARB_SCOREBOARD_EN to include the per-register
// pending-load scoreboard; otherwise mark_rdy is tied 1 and hazard tied 0.
module rf_wb_arb
    import rf_wb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
)(
    input  logic        clk,
    input  logic        reset,
    rf_wb_arb_if.slave  bus
);

    logic [NREQ-1:0]      req, gnt;
    logic                 xfer;
    logic [ADDR_SIZE-1:0] wa_sel;
    logic [WIDTH-1:0]     din_sel;

    // link_req owns the write port for the cycle, so nobody may be granted.
    assign req  = bus.link_req ? '0 : {bus.req_dbg, bus.req_mem, bus.req_alu};
    assign xfer = |gnt;

    rr_arb3 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign bus.gnt_alu = gnt[REQ_ALU];
    assign bus.gnt_mem = gnt[REQ_MEM];
    assign bus.gnt_dbg = gnt[REQ_DBG];

    always_comb begin
        wa_sel  = bus.wa_alu;
        din_sel = bus.din_alu;
        if (gnt[REQ_MEM]) begin
            wa_sel  = bus.wa_mem;
            din_sel = bus.din_mem;
        end else if (gnt[REQ_DBG]) begin
            wa_sel  = bus.wa_dbg;
            din_sel = bus.din_dbg;
        end
    end

    // Address and data only load on a transfer so they hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rf_wen  <= 1'b0;
            bus.rf_link <= 1'b0;
            bus.rf_wa   <= '0;
            bus.rf_din  <= '0;
        end else begin
            bus.rf_wen  <= xfer;
            bus.rf_link <= bus.link_req;
            if (xfer) begin
                bus.rf_wa  <= wa_sel;
                bus.rf_din <= din_sel;
            end
        end
    end

`ifdef RF_WB_ARB_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_SIZE;

    logic [NREG-1:0] pend, pend_n;

    assign bus.mark_rdy = ~pend[bus.mark_addr];
    assign bus.hazard   = pend[bus.qa] | pend[bus.qb];

    // Set is applied after clear so a same-address mark wins over the load
    // returning in the same cycle.
    always_comb begin
        pend_n = pend;
        if (gnt[REQ_MEM])
            pend_n[bus.wa_mem] = 1'b0;
        if (bus.mark_req && bus.mark_rdy)
            pend_n[bus.mark_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= '0;
        else       pend <= pend_n;
    end
`else
    logic unused_sb;

    assign bus.mark_rdy = 1'b1;
    assign bus.hazard   = 1'b0;
    assign unused_sb    = ^{bus.mark_req, bus.mark_addr, bus.qa, bus.qb};
`endif

endmodule
